// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer owning the PC and instruction register.
// Optional performance counters are enabled with `define SEQ_PERF_CNT_EN.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          INST_TYPE_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ready,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            inst,
    input  logic [INST_TYPE_W-1:0] dec_type,
    input  logic                   dec_ebreak,
    output logic [31:0]            pc,
    output logic                   rf_we,
    output logic                   busy,
    output logic                   halt,
    output logic                   trap,
`ifdef SEQ_PERF_CNT_EN
    output logic [63:0]            cycle_cnt,
    output logic [63:0]            instret_cnt,
`endif
    output logic [2:0]             dbg_state
);

    // A trapping halt is its own state so that trap is decoded from the state register.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t state;
    state_t state_next;

    // Fetch handshake: imem_req is held with imem_addr stable until imem_ready;
    // the transfer (and capture of imem_rdata) happens on the edge where both are high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            inst  <= NOP;
        end else begin
            state <= state_next;
            if (state == S_FETCH && imem_ready) begin
                inst <= imem_rdata;
            end
            if (state == S_WB) begin
                pc <= pc + 32'd4;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (run) state_next = S_FETCH;
            S_FETCH:  if (imem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (dec_ebreak) begin
                    state_next = S_HALT;
                end else if (dec_type == '0) begin
                    state_next = S_TRAP;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        rf_we    = 1'b0;
        busy     = 1'b0;
        halt     = 1'b0;
        trap     = 1'b0;
        case (state)
            S_FETCH:  begin imem_req = 1'b1; busy = 1'b1; end
            S_DECODE: busy = 1'b1;
            S_EXEC:   busy = 1'b1;
            S_WB:     begin rf_we = 1'b1; busy = 1'b1; end
            S_HALT:   halt = 1'b1;
            S_TRAP:   begin halt = 1'b1; trap = 1'b1; end
            default:  ;
        endcase
    end

    assign imem_addr = pc;
    assign dbg_state = state;

`ifdef SEQ_PERF_CNT_EN
    // Both counters freeze naturally in HALT because busy and rf_we are low there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            if (busy) cycle_cnt <= cycle_cnt + 64'd1;
            if (rf_we) instret_cnt <= instret_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: each expected write-back {cycle, pc, inst} is queued
// by the stimulus and checked by a monitor whenever rf_we is presented.
module tb_cpu_sequencer;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] BAD    = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI0  = 32'h0010_0093;
    localparam logic [31:0] ADDI1  = 32'h0020_8113;
    localparam logic [31:0] ADDI2  = 32'h0031_0193;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    logic [31:0] t0  = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // main DUT signals
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [2:0]  dec_type;
    logic        dec_ebreak;
    logic [31:0] pc;
    logic        rf_we, busy, halt, trap;
    logic [2:0]  dbg_state;
`ifdef SEQ_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;
    logic [63:0] cycle_cnt_w, instret_cnt_w;
`endif

    // wrap-around instance signals
    logic        run_w;
    logic        req_w;
    logic [31:0] addr_w, inst_w, pc_w;
    logic        we_w, busy_w, halt_w, trap_w;
    logic [2:0]  dbg_w;

    // memory and decoder models
    logic [31:0] mem [0:7];
    logic        ready_en;
    logic        ebreak_type0;

    assign imem_ready = ready_en;
    assign imem_rdata = mem[imem_addr[4:2]];

    always_comb begin
        dec_ebreak = (inst == EBREAK);
        dec_type   = 3'd1;
        if (inst == BAD) dec_type = 3'd0;
        if (inst == EBREAK && ebreak_type0) dec_type = 3'd0;
    end

    cpu_sequencer #(.RESET_PC(RST_PC), .INST_TYPE_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .dec_type   (dec_type),
        .dec_ebreak (dec_ebreak),
        .pc         (pc),
        .rf_we      (rf_we),
        .busy       (busy),
        .halt       (halt),
        .trap       (trap),
`ifdef SEQ_PERF_CNT_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .dbg_state  (dbg_state)
    );

    cpu_sequencer #(.RESET_PC(32'hFFFF_FFFC), .INST_TYPE_W(3)) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run_w),
        .imem_req   (req_w),
        .imem_addr  (addr_w),
        .imem_ready (1'b1),
        .imem_rdata (ADDI0),
        .inst       (inst_w),
        .dec_type   (3'd1),
        .dec_ebreak (1'b0),
        .pc         (pc_w),
        .rf_we      (we_w),
        .busy       (busy_w),
        .halt       (halt_w),
        .trap       (trap_w),
`ifdef SEQ_PERF_CNT_EN
        .cycle_cnt  (cycle_cnt_w),
        .instret_cnt(instret_cnt_w),
`endif
        .dbg_state  (dbg_w)
    );

    // scoreboard
    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    logic [95:0] exp_q [$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("rf_we_unexpected", {cyc - t0, pc, inst}, 96'd0);
            end else begin
                check("writeback", {cyc - t0, pc, inst}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        run_w = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        for (int i = 0; i < 8; i++) mem[i] = NOP;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[3] = w3;
    endtask

    // Raise run for one cycle; returns one cycle later (relative cycle 1).
    task automatic go();
        run = 1'b1;
        t0  = cyc;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 60 && halt !== 1'b1; i++) @(negedge clk);
        check("reach_halt", {95'd0, halt}, 96'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        int   we0;
        logic [31:0] pc_hold;

        rst_n = 1'b0;
        run = 1'b0;
        run_w = 1'b0;
        ready_en = 1'b1;
        ebreak_type0 = 1'b0;
        load(NOP, NOP, NOP, NOP);
        repeat (2) @(negedge clk);

        // reset state
        check("reset_pc", pc, RST_PC);
        check("reset_inst", inst, NOP);
        check("reset_outs", {imem_req, rf_we, busy, halt, trap}, 5'b0);
`ifdef SEQ_PERF_CNT_EN
        check("reset_cnts", {cycle_cnt, instret_cnt}, 128'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= imem_req | halt;
        end
        check("idle_no_req", seen, 1'b0);

        // three addi then ebreak, zero wait states: write-backs at cycles 4, 8, 12
        load(ADDI0, ADDI1, ADDI2, EBREAK);
        exp_q.push_back({32'd4,  RST_PC,         ADDI0});
        exp_q.push_back({32'd8,  RST_PC + 32'd4, ADDI1});
        exp_q.push_back({32'd12, RST_PC + 32'd8, ADDI2});
        we0 = we_cnt;
        go();
        check("run_req", {imem_req, imem_addr}, {1'b1, RST_PC});
        repeat (12) @(negedge clk);
        check("pc_after3", pc, RST_PC + 32'd12);
`ifdef SEQ_PERF_CNT_EN
        check("cnt_after3", {cycle_cnt, instret_cnt}, {64'd12, 64'd3});
`endif
        wait_halt();
        check("a_halt", {halt, trap, pc}, {1'b1, 1'b0, RST_PC + 32'd12});
        check("a_we_count", we_cnt - we0, 3);
`ifdef SEQ_PERF_CNT_EN
        // ebreak's FETCH and DECODE cycles are also busy
        check("cnt_halt", {cycle_cnt, instret_cnt}, {64'd14, 64'd3});
`endif

        // five wait states on the first fetch: that instruction retires at cycle 9
        do_reset();
        load(ADDI1, ADDI2, EBREAK, NOP);
        ready_en = 1'b0;
        exp_q.push_back({32'd9,  RST_PC,         ADDI1});
        exp_q.push_back({32'd13, RST_PC + 32'd4, ADDI2});
        go();
        for (int i = 1; i <= 6; i++) begin
            check("wait_fetch", {imem_req, imem_addr, inst}, {1'b1, RST_PC, NOP});
            if (i < 6) @(negedge clk);
        end
        ready_en = 1'b1;
        @(negedge clk);
        check("wait_captured", {imem_req, dbg_state, inst}, {1'b0, 3'd2, ADDI1});
        wait_halt();
        check("b_halt", {halt, trap, pc}, {1'b1, 1'b0, RST_PC + 32'd8});

        // ebreak at 8000_0004: no write-back, stays halted
        do_reset();
        load(ADDI0, EBREAK, NOP, NOP);
        exp_q.push_back({32'd4, RST_PC, ADDI0});
        we0 = we_cnt;
        go();
        wait_halt();
        check("c_halt", {halt, trap, pc, inst}, {1'b1, 1'b0, RST_PC + 32'd4, EBREAK});
        check("c_we_count", we_cnt - we0, 1);
        pc_hold = pc;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen |= rf_we | imem_req | busy | ~halt | (pc != pc_hold);
        end
        check("c_hold100", seen, 1'b0);
`ifdef SEQ_PERF_CNT_EN
        check("c_instret", instret_cnt, 64'd1);
`endif

        // unsupported instruction traps
        do_reset();
        load(BAD, NOP, NOP, NOP);
        we0 = we_cnt;
        go();
        wait_halt();
        check("d_trap", {halt, trap, pc}, {1'b1, 1'b1, RST_PC});
        check("d_we_count", we_cnt - we0, 0);

        // ebreak wins over an unsupported type
        do_reset();
        ebreak_type0 = 1'b1;
        load(EBREAK, NOP, NOP, NOP);
        go();
        wait_halt();
        check("e_ebreak_wins", {halt, trap, pc}, {1'b1, 1'b0, RST_PC});
        ebreak_type0 = 1'b0;

        // reset while FETCH waits; a late ready must not load inst
        do_reset();
        load(ADDI0, NOP, NOP, NOP);
        ready_en = 1'b0;
        go();
        repeat (2) @(negedge clk);
        check("f_waiting", {imem_req, inst}, {1'b1, NOP});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready_en = 1'b1;
        check("f_reset", {imem_req, busy, pc, inst}, {1'b0, 1'b0, RST_PC, NOP});
        @(negedge clk);
        check("f_late_ready", {imem_req, dbg_state, inst}, {1'b0, 3'd0, NOP});

        // pc wraps from FFFF_FFFC to 0
        do_reset();
        run_w = 1'b1;
        @(negedge clk);
        run_w = 1'b0;
        check("w_first_addr", {req_w, addr_w}, {1'b1, 32'hFFFF_FFFC});
        repeat (4) @(negedge clk);
        check("w_wrapped", {req_w, pc_w, addr_w}, {1'b1, 32'd0, 32'd0});

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle sequencer for the single-issue NPC core. It steps every instruction through fetch, decode, execute and write-back. It owns the PC and the instruction register, handshakes with instruction memory, and sends the latched instruction to the decode unit. It halts permanently on `ebreak` or on an instruction the decoder does not recognise.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `INST_TYPE_W`, default 3: width of the decoder instruction-type input. A value of 0 means unsupported.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `run`  in  1  start/continue enable; sampled only in IDLE.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals `pc` while `imem_req` is high.
- `imem_ready`  in  1  memory accepts the request and `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `inst`  out  32  instruction register; feeds the decoder.
- `dec_type`  in  INST_TYPE_W  decoder instruction-type result for `inst`.
- `dec_ebreak`  in  1  decoder flags `inst` as `ebreak`.
- `pc`  out  32  current PC.
- `rf_we`  out  1  register-file write enable; a one-cycle pulse in WB.
- `busy`  out  1  high in FETCH, DECODE, EXEC and WB.
- `halt`  out  1  sticky; high in HALT.
- `trap`  out  1  sticky; high if the halt was caused by an unsupported instruction.

## Operation
- States and transitions:
  - IDLE: goes to FETCH when `run`=1.
  - FETCH: goes to DECODE on `imem_req && imem_ready`.
  - DECODE: goes to HALT if `dec_ebreak`=1. Otherwise goes to HALT with `trap`=1 if `dec_type`=0. Otherwise goes to EXEC.
  - EXEC: always goes to WB.
  - WB: always goes to FETCH.
  - HALT: absorbing; only reset leaves it.
- FETCH drives `imem_req`=1 and `imem_addr`=`pc`. The request is held with a stable address until `imem_ready`. On the handshake edge, `inst` <= `imem_rdata`.
- `imem_ready` is ignored outside FETCH.
- WB drives `rf_we`=1. On the WB edge, `pc` <= `pc` + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- `pc` changes only on a WB edge or on reset.
- `ebreak` is not written back and does not advance `pc`. In HALT, `pc` holds the address of the halting instruction.
- If `dec_ebreak` and `dec_type`=0 are both true in DECODE, `ebreak` wins and `trap` stays 0.
- `run` deasserting after leaving IDLE has no effect. The sequencer runs freely until HALT.
- All outputs except `inst` and `pc` are decoded from the state register. There are no combinational paths from inputs to outputs.

## Timing
- Reset values:
  - state IDLE
  - `pc`=RESET_PC
  - `inst`=32'h0000_0013 (nop)
  - `imem_req`=0, `rf_we`=0, `busy`=0, `halt`=0, `trap`=0
  - performance counters = 0
- Reset during a fetch or any other state: on the edge where `rst_n`=0, all registers take their reset values, so `imem_req` is low from the next cycle. A pending memory response is dropped.
- Latency with zero wait states: 4 cycles per instruction, F-D-E-W. Each cycle `imem_ready` is held low adds one cycle.
- `run` high in IDLE → `imem_req` high in the following cycle.
- `rf_we` is high for exactly one cycle per retired non-`ebreak` instruction.

## Configuration
- `SEQ_PERF_CNT_EN`: when defined, adds two outputs:
  - `cycle_cnt` (64): counts every cycle in which `busy`=1.
  - `instret_cnt` (64): increments on each WB edge.
  - Both freeze in HALT, reset to 0, and wrap at 2^64.
- When the macro is not defined, both ports and counters are absent and the remaining behaviour is identical.

## Test plan
- Reset with `run`=0 → `pc`=32'h8000_0000, `halt`=0, `imem_req`=0 indefinitely. Raise `run` → `imem_req`=1 next cycle with `imem_addr`=32'h8000_0000.
- Three addi words, `dec_type`=1, `imem_ready` tied high → exactly 3 `rf_we` pulses 4 cycles apart. `pc` ends at 32'h8000_000C. With the macro defined, `instret_cnt`=3 and `cycle_cnt`=12.
- `imem_ready` held low 5 cycles in FETCH → `imem_addr` stable throughout and `inst` updated only on the ready cycle. That instruction takes 9 cycles.
- 32'h0010_0073 with `dec_ebreak`=1 at `pc`=32'h8000_0004 → HALT after DECODE, `halt`=1, `trap`=0, `pc`=32'h8000_0004, no `rf_we`. Stays halted for 100 cycles.
- `dec_type`=0 with `dec_ebreak`=0 → `halt`=1, `trap`=1. Both `dec_type`=0 and `dec_ebreak`=1 → `halt`=1, `trap`=0.
- `rst_n` low for one cycle while FETCH waits on `imem_ready` → IDLE next cycle, `pc`=RESET_PC, `imem_req`=0. A late `imem_ready` pulse leaves `inst`=32'h0000_0013.
